sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 Parameter RD_CYCLES, default 2, legal 1..7, OE-low cycles per read.
REQ-004 Parameter WR_CYCLES, default 1, legal 1..7, WE-low cycles per write.
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- mem_req  in  1  data-stage request.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data.
- mem_valid  out  1  one-cycle pulse: data access complete.
- hold  out  1  stall to PC/IF: if_req & ~if_valid.
- mem_stall  out  1  stall to pipeline: mem_req & ~mem_valid.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dq_o  out  DATA_W  write data to top-level tri-state.
- sram_dq_oe  out  1  1 = top level drives sram_dq_o onto the bus.
- sram_dq_i  in  DATA_W  data bus sampled from the SRAM.
- sram_oe_n, sram_we_n, sram_en_n  out  1 each  active-low SRAM strobes.

Function
REQ-006 FSM states SHALL be: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-007 In IDLE, on the edge with mem_req=1, the block SHALL latch mem_addr, mem_we and mem_wdata, grant MEM, and go to RD (mem_we=0) or WR_SETUP (mem_we=1); MEM has fixed priority over IF.
REQ-008 In IDLE with mem_req=0 and if_req=1, the block SHALL latch if_addr, grant IF, and go to RD.
REQ-009 RD SHALL last exactly RD_CYCLES cycles with sram_oe_n=0 and sram_dq_oe=0; the last RD edge SHALL capture sram_dq_i into the granted requester's rdata register and return to IDLE.
REQ-010 Writes SHALL follow this sequence:
- WR_SETUP: 1 cycle, sram_we_n=1.
- WR_PULSE: WR_CYCLES cycles, sram_we_n=0.
- WR_HOLD: 1 cycle, sram_we_n=1.
- sram_dq_oe=1 and sram_addr/sram_dq_o stable throughout all three states; then IDLE.
REQ-011 The valid pulse (if_valid or mem_valid, never both) SHALL be asserted for exactly the first IDLE cycle after an access completes.
REQ-012 A new request SHALL be acceptable in that same IDLE cycle, giving throughput of one read per RD_CYCLES+1 cycles and one write per WR_CYCLES+3 cycles.
REQ-013 Read latency from acceptance edge to valid SHALL be RD_CYCLES+1 cycles.
REQ-014 sram_addr, sram_dq_o, sram_dq_oe, sram_oe_n and sram_we_n SHALL be registered outputs (glitch-free).
REQ-015 sram_oe_n and sram_we_n SHALL never be 0 simultaneously.
REQ-016 sram_dq_oe SHALL be 0 in every cycle in which sram_oe_n=0.
REQ-017 Requester inputs SHALL be ignored while not in IDLE.
REQ-018 A request deasserted mid-access SHALL NOT abort the access; the access completes and valid still pulses.
REQ-019 When mem_req and if_req both stay asserted, IF SHALL wait, and hold SHALL remain 1, until mem_req drops.
REQ-020 if_rdata and mem_rdata SHALL hold their last captured value until the next capture for the same requester.
REQ-021 The wait counter SHALL be 3 bits; each state's count SHALL be loaded on state entry and decremented to zero with no wrap-around.

Reset
REQ-022 While rst=1, the block SHALL immediately, asynchronously, set:
- state = IDLE; counter = 0.
- sram_oe_n = 1, sram_we_n = 1, sram_en_n = 1, sram_dq_oe = 0.
- sram_addr = 0, sram_dq_o = 0.
- if_rdata = 0, mem_rdata = 0; if_valid = 0, mem_valid = 0.
REQ-023 After rst falls, sram_en_n SHALL be 0 from the first clock edge onward.
REQ-024 Reset asserted mid-access SHALL abort the access with no valid pulse, and strobes SHALL deassert within the same cycle.

Structure
REQ-025 FSM state encodings, ADDR_W/DATA_W defaults and the strobe polarity constants SHALL reside in the shared definitions package mem_defs.
REQ-026 The RD_CYCLES/WR_CYCLES countdown SHALL be a sub-module access_timer (inputs load, load value; output done).

Verification
REQ-027 IF-only read, RD_CYCLES=2, if_addr=0x00010, SRAM model returns 0x1234:
- oe_n low for 2 cycles.
- if_valid on cycle 3 with if_rdata=0x1234.
- hold=1 on cycles 0-2, 0 on cycle 3.
REQ-028 MEM write, mem_addr=0x00200, wdata=0xBEEF, WR_CYCLES=1:
- Strobes: setup / 1 WE-low cycle / hold.
- dq_oe=1 for 3 cycles; mem_valid on cycle 4.
- Model holds 0xBEEF at 0x200.
REQ-029 Simultaneous if_req and mem_req read (0x00300) on the same edge:
- MEM served first, mem_valid at cycle 3.
- IF accepted in that same cycle, if_valid at cycle 6.
REQ-030 Back-to-back IF reads 0x0, 0x1, 0x2 with if_req held:
- if_valid pulses every 3 cycles.
- sram_oe_n high exactly one cycle between reads.
REQ-031 rst asserted during WR_PULSE:
- we_n=1 and dq_oe=0 within the same cycle; no mem_valid.
- After release, the next read of 0x0 completes normally.
REQ-032 All scenarios:
- Assertion that oe_n=0 and we_n=0 never coincide.
- Assertion that dq_oe=1 and oe_n=0 never coincide.

Source files
------------

// File: rtl/mem_defs.sv
// Shared SRAM arbiter definitions: FSM encoding, bus width defaults, strobe levels
// and the wait-count helper used by both the arbiter and its timer.
package mem_defs;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 3;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } arb_state_t;

  // A state lasting N cycles loads N-1 and leaves when the count reaches zero.
  function automatic logic [CNT_W-1:0] cycles_to_count(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/access_timer.sv
// Per-state wait counter: loaded on state entry, counts down to zero and sticks there.
// done is combinational from the count, so it is valid in the last cycle of the state.
module access_timer
  import mem_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// IF/MEM arbiter onto an async SRAM; valid pulses RD_CYCLES+1 (read) or WR_CYCLES+3 (write) cycles after request.
// Requesters are stalled via hold/mem_stall while the SRAM is busy; MEM has fixed priority over IF.
module sram_arbiter
  import mem_defs::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              hold,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_en_n
);

  localparam logic [CNT_W-1:0] RD_LOAD  = cycles_to_count(RD_CYCLES);
  localparam logic [CNT_W-1:0] WR_LOAD  = cycles_to_count(WR_CYCLES);
  localparam logic [CNT_W-1:0] ONE_LOAD = cycles_to_count(1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_done;
  logic             acc_mem;
  logic             acc_if;
  logic             gnt_mem;
  logic             rd_done;

  access_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = ONE_LOAD;
    acc_mem   = 1'b0;
    acc_if    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          acc_mem = 1'b1;
          t_load  = 1'b1;
          if (mem_we) begin
            state_nxt = WR_SETUP;
            t_val     = ONE_LOAD;
          end else begin
            state_nxt = RD;
            t_val     = RD_LOAD;
          end
        end else if (if_req) begin
          acc_if    = 1'b1;
          t_load    = 1'b1;
          t_val     = RD_LOAD;
          state_nxt = RD;
        end
      end
      RD: begin
        if (t_done) state_nxt = IDLE;
      end
      WR_SETUP: begin
        if (t_done) begin
          state_nxt = WR_PULSE;
          t_load    = 1'b1;
          t_val     = WR_LOAD;
        end
      end
      WR_PULSE: begin
        if (t_done) begin
          state_nxt = WR_HOLD;
          t_load    = 1'b1;
          t_val     = ONE_LOAD;
        end
      end
      WR_HOLD: begin
        if (t_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_done = (state == RD) && t_done;

  // Strobes are registered from the next state so the pins change only on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_oe_n  <= STROBE_OFF;
      sram_we_n  <= STROBE_OFF;
      sram_en_n  <= STROBE_OFF;
      sram_dq_oe <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      gnt_mem    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_valid   <= 1'b0;
      mem_valid  <= 1'b0;
    end else begin
      sram_en_n  <= STROBE_ON;
      sram_oe_n  <= (state_nxt == RD) ? STROBE_ON : STROBE_OFF;
      sram_we_n  <= (state_nxt == WR_PULSE) ? STROBE_ON : STROBE_OFF;
      sram_dq_oe <= (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});

      if (acc_mem) begin
        sram_addr <= mem_addr;
        sram_dq_o <= mem_wdata;
        gnt_mem   <= 1'b1;
      end else if (acc_if) begin
        sram_addr <= if_addr;
        gnt_mem   <= 1'b0;
      end

      if_valid  <= rd_done && !gnt_mem;
      mem_valid <= (rd_done && gnt_mem) || ((state == WR_HOLD) && t_done);

      if (rd_done && !gnt_mem) if_rdata  <= sram_dq_i;
      if (rd_done && gnt_mem)  mem_rdata <= sram_dq_i;
    end
  end

  assign hold      = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, directed vector table, corner sequences
// and a transaction-level reference model driven by random request streams.
module tb_sram_arbiter;

  localparam int AW  = 18;
  localparam int DW  = 16;
  localparam int RDC = 2;
  localparam int WRC = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          hold;
  logic          mem_stall;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_o;
  logic          sram_dq_oe;
  logic [DW-1:0] sram_dq_i = '0;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_en_n;

  always #5 clk = ~clk;

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RDC), .WR_CYCLES(WRC)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .hold(hold), .mem_stall(mem_stall),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_en_n(sram_en_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Async SRAM: unwritten locations read back a fixed address-derived pattern.
  logic [DW-1:0] sram_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h1224;
  endfunction

  function automatic logic [DW-1:0] sram_peek(input logic [AW-1:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return pattern(a);
  endfunction

  always @(posedge clk)
    if (!sram_en_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_o;

  always @(negedge clk) sram_dq_i = sram_peek(sram_addr);

  always @(negedge clk)
    if (!rst) begin
      chk("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      chk("dq_oe_while_oe", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
    end

  // Per-cycle traces, bit c = cycle c of the current transaction.
  logic [31:0] tr_oe_n, tr_we_n, tr_dq_oe, tr_hold, tr_stall, tr_ifv, tr_memv;

  task automatic rec(input int c);
    if (c == 0) begin
      tr_oe_n = '0; tr_we_n = '0; tr_dq_oe = '0; tr_hold = '0;
      tr_stall = '0; tr_ifv = '0; tr_memv = '0;
    end
    if (c < 32) begin
      tr_oe_n[c] = sram_oe_n;  tr_we_n[c] = sram_we_n; tr_dq_oe[c] = sram_dq_oe;
      tr_hold[c] = hold;       tr_stall[c] = mem_stall;
      tr_ifv[c]  = if_valid;   tr_memv[c] = mem_valid;
    end
  endtask

  task automatic run_txn(input bit is_mem, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int lat);
    @(negedge clk);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    #1 rec(0);
    lat = -1;
    for (int c = 1; c < 24 && lat < 0; c++) begin
      @(negedge clk);
      rec(c);
      if (is_mem ? mem_valid : if_valid) lat = c;
    end
    mem_req = 1'b0;
    if_req  = 1'b0;
  endtask

  typedef struct {
    bit            is_mem;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
    int            exp_lat;
  } vec_t;

  vec_t vt [8];

  // Reference model state for the random phase.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  int            lat, mv, iv, k, spurious, due, ndone;
  int            vcyc [3];
  logic [DW-1:0] exp_if, exp_mem, own_exp;
  bit            busy, own_mem, own_rd, ifp, memp, mw, exp_iv, exp_mv;
  logic [AW-1:0] ia, ma;
  logic [DW-1:0] md;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 0, 18'h00010, 16'h0000, 16'h1234, 3};
    vt[1] = '{1, 1, 18'h00200, 16'hBEEF, 16'hBEEF, 4};
    vt[2] = '{1, 0, 18'h00200, 16'h0000, 16'hBEEF, 3};
    vt[3] = '{0, 0, 18'h00200, 16'h0000, 16'hBEEF, 3};
    vt[4] = '{1, 1, 18'h003FF, 16'h0001, 16'h0001, 4};
    vt[5] = '{0, 0, 18'h003FF, 16'h0000, 16'h0001, 3};
    vt[6] = '{1, 0, 18'h00010, 16'h0000, 16'h1234, 3};
    vt[7] = '{0, 0, 18'h3FFFF, 16'h0000, 16'hEDDB, 3};

    // Reset state, checked both before and after the first clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_en_n", 32'(sram_en_n), 32'd1);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_o", 32'(sram_dq_o), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_en_n_held", 32'(sram_en_n), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("en_n_after_rst", 32'(sram_en_n), 32'd0);

    // Vector table.
    exp_if = '0; exp_mem = '0;
    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].is_mem, vt[i].we, vt[i].addr, vt[i].wdata, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
      if (vt[i].we) chk($sformatf("vec%0d_sram_content", i), 32'(sram_peek(vt[i].addr)), 32'(vt[i].exp_rd));
      else if (vt[i].is_mem) exp_mem = vt[i].exp_rd;
      else exp_if = vt[i].exp_rd;
      chk($sformatf("vec%0d_if_rdata", i), 32'(if_rdata), 32'(exp_if));
      chk($sformatf("vec%0d_mem_rdata", i), 32'(mem_rdata), 32'(exp_mem));
    end

    // IF-only read waveform.
    run_txn(0, 0, 18'h00010, 16'h0, lat);
    chk("ifrd_oe_n_trace", 32'(tr_oe_n[3:0]), 32'(4'b1001));
    chk("ifrd_hold_trace", 32'(tr_hold[3:0]), 32'(4'b0111));
    chk("ifrd_valid_trace", 32'(tr_ifv[3:0]), 32'(4'b1000));
    chk("ifrd_data", 32'(if_rdata), 32'h1234);

    // MEM write waveform.
    run_txn(1, 1, 18'h00200, 16'hBEEF, lat);
    chk("wr_we_n_trace", 32'(tr_we_n[4:0]), 32'(5'b11011));
    chk("wr_dq_oe_trace", 32'(tr_dq_oe[4:0]), 32'(5'b01110));
    chk("wr_oe_n_trace", 32'(tr_oe_n[4:0]), 32'(5'b11111));
    chk("wr_valid_trace", 32'(tr_memv[4:0]), 32'(5'b10000));
    chk("wr_model", 32'(sram_peek(18'h00200)), 32'hBEEF);

    // Simultaneous requests: MEM first, IF accepted in the MEM valid cycle.
    @(negedge clk);
    if_req = 1'b1; if_addr = 18'h00040;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00300;
    #1 rec(0);
    mv = -1; iv = -1;
    for (int c = 1; c < 24 && iv < 0; c++) begin
      @(negedge clk);
      rec(c);
      if (mem_valid) begin mv = c; mem_req = 1'b0; end
      if (if_valid)  begin iv = c; if_req = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("both_mem_valid_cycle", 32'(mv), 32'd3);
    chk("both_if_valid_cycle", 32'(iv), 32'd6);
    chk("both_hold_trace", 32'(tr_hold[6:0]), 32'(7'b0111111));
    chk("both_stall_trace", 32'(tr_stall[3:0]), 32'(4'b0111));
    chk("both_mem_data", 32'(mem_rdata), 32'h1124);
    chk("both_if_data", 32'(if_rdata), 32'h1264);

    // Back-to-back IF reads with if_req held.
    @(negedge clk);
    if_req = 1'b1; if_addr = 18'h0;
    #1 rec(0);
    k = 0;
    for (int c = 1; c < 32 && k < 3; c++) begin
      @(negedge clk);
      rec(c);
      if (if_valid) begin
        chk($sformatf("b2b_data%0d", k), 32'(if_rdata), 32'(pattern(AW'(k))));
        vcyc[k] = c;
        k++;
        if (k < 3) if_addr = AW'(k);
        else if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    chk("b2b_count", 32'(k), 32'd3);
    chk("b2b_valid0", 32'(vcyc[0]), 32'd3);
    chk("b2b_valid1", 32'(vcyc[1]), 32'd6);
    chk("b2b_valid2", 32'(vcyc[2]), 32'd9);
    chk("b2b_oe_n_trace", 32'(tr_oe_n[9:0]), 32'(10'b1001001001));

    // Request dropped mid-access and inputs changed while busy.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00020;
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'b1; mem_addr = 18'h00099;
    lat = -1;
    for (int c = 2; c < 16 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_valid) lat = c;
    end
    chk("drop_latency", 32'(lat), 32'd3);
    chk("drop_data", 32'(mem_rdata), 32'h1204);
    @(negedge clk);
    chk("drop_no_reaccept_oe", 32'(sram_oe_n), 32'd1);
    chk("drop_no_reaccept_dq_oe", 32'(sram_dq_oe), 32'd0);
    mem_we = 1'b0;

    // Reset during WR_PULSE.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00155; mem_wdata = 16'hAAAA;
    @(negedge clk);
    mem_req = 1'b0;
    @(negedge clk);
    chk("rstwr_in_pulse", 32'(sram_we_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstwr_we_n", 32'(sram_we_n), 32'd1);
    chk("rstwr_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstwr_oe_n", 32'(sram_oe_n), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_valid || mem_valid) spurious++;
    end
    chk("rstwr_no_valid", 32'(spurious), 32'd0);
    run_txn(0, 0, 18'h0, 16'h0, lat);
    chk("rstwr_read_latency", 32'(lat), 32'd3);
    chk("rstwr_read_data", 32'(if_rdata), 32'h1224);

    // Random request streams against the transaction-level model.
    busy = 0; ifp = 0; memp = 0; ndone = 0; due = 0; own_mem = 0; own_rd = 0; own_exp = '0;
    mw = 0; ma = '0; md = '0; ia = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      exp_iv = busy && (due == c) && !own_mem;
      exp_mv = busy && (due == c) && own_mem;
      chk("rnd_if_valid", 32'(if_valid), 32'(exp_iv));
      chk("rnd_mem_valid", 32'(mem_valid), 32'(exp_mv));
      if (busy && due == c) begin
        if (own_rd) chk("rnd_rdata", 32'(own_mem ? mem_rdata : if_rdata), 32'(own_exp));
        if (own_mem) memp = 0; else ifp = 0;
        busy = 0;
        ndone++;
      end
      if (c < 760) begin
        if (!memp && $urandom_range(0, 3) == 0) begin
          memp = 1; mw = 1'($urandom_range(0, 1));
          ma = AW'(18'h400 + $urandom_range(0, 63)); md = DW'($urandom);
        end
        if (!ifp && $urandom_range(0, 2) == 0) begin
          ifp = 1; ia = AW'(18'h400 + $urandom_range(0, 63));
        end
      end
      mem_req = memp; mem_we = mw; mem_addr = ma; mem_wdata = md;
      if_req = ifp; if_addr = ia;
      #1;
      chk("rnd_hold", 32'(hold), 32'(ifp && !exp_iv));
      chk("rnd_mem_stall", 32'(mem_stall), 32'(memp && !exp_mv));
      if (!busy) begin
        if (memp) begin
          busy = 1; own_mem = 1; own_rd = !mw;
          if (mw) begin
            due = c + WRC + 3; ref_mem[ma] = md;
          end else begin
            due = c + RDC + 1; own_exp = ref_rd(ma);
          end
        end else if (ifp) begin
          busy = 1; own_mem = 0; own_rd = 1;
          due = c + RDC + 1; own_exp = ref_rd(ia);
        end
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("rnd_drained", 32'(busy || ifp || memp), 32'd0);
    chk("rnd_enough_completions", 32'(ndone > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
